// File: rtl/fpcvt_sched_pkg.sv
// Shared types and widths for the two-requester FPCVT conversion scheduler.
package fpcvt_sched_pkg;

  localparam int unsigned SAMPLE_W = 13;
  localparam int unsigned MAG_W    = 12;
  localparam int unsigned EXP_W    = 3;
  localparam int unsigned FRAC_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
  } fp_t;

endpackage

// File: rtl/fpcvt_sched_fpcvt.sv
// FPCVT: 13-bit two's-complement sample to sign / 3-bit exponent / 5-bit
// significand, value ~= F * 2^E, rounded on the bit below the significand.
module fpcvt_sched_fpcvt
  import fpcvt_sched_pkg::*;
(
  input  logic [SAMPLE_W-1:0] d,
  output fp_t                 res_c
);

  logic [MAG_W-1:0]  mag;
  logic [3:0]        msb;
  logic [EXP_W-1:0]  e_raw;
  logic [FRAC_W-1:0] f_raw;
  logic              rnd;
  logic [FRAC_W:0]   sum;

  always_comb begin
    // -4096 has no positive 12-bit counterpart, so it saturates to 4095
    if (!d[SAMPLE_W-1])
      mag = d[MAG_W-1:0];
    else if (d == {1'b1, {(SAMPLE_W-1){1'b0}}})
      mag = '1;
    else
      mag = MAG_W'(~d + SAMPLE_W'(1));

    msb = '0;
    for (int i = 0; i < int'(MAG_W); i++)
      if (mag[i]) msb = 4'(i);

    e_raw = (msb > 4'd4) ? 3'(msb - 4'd4) : '0;
    f_raw = FRAC_W'(mag >> e_raw);
    rnd   = (e_raw != '0) ? mag[e_raw - 3'd1] : 1'b0;
    sum   = {1'b0, f_raw} + (FRAC_W+1)'(rnd);

    res_c.s = d[SAMPLE_W-1];
    if (sum[FRAC_W]) begin
      if (e_raw == 3'd7) begin
        res_c.e = 3'd7;
        res_c.f = 5'd31;
      end else begin
        res_c.e = e_raw + 3'd1;
        res_c.f = 5'd16;
      end
    end else begin
      res_c.e = e_raw;
      res_c.f = sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one FPCVT datapath between two requesters,
// with a registered valid/ready result port and a handshake counter.
module fpcvt_sched
  import fpcvt_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [SAMPLE_W-1:0] req0_d,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [SAMPLE_W-1:0] req1_d,
  output logic                req1_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_s,
  output logic [EXP_W-1:0]    out_e,
  output logic [FRAC_W-1:0]   out_f,
  output logic                out_id,
  output logic [CNT_W-1:0]    conv_count
);

  state_t              state, state_nxt;
  logic                last_grant;
  logic                grant;
  logic                accept;
  logic                handshake;
  logic                win;
  logic [SAMPLE_W-1:0] samp_q;
  logic                id_q;
  fp_t                 cvt_res;
  fp_t                 res_q;

  fpcvt_sched_fpcvt u_fpcvt (
    .d     (samp_q),
    .res_c (cvt_res)
  );

  // Arbitration, accept window and next state
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    handshake  = 1'b0;
    win        = 1'b0;
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    case (state)
      ST_IDLE: win = 1'b1;
      ST_OUT: begin
        win       = out_ready;
        handshake = out_ready;
      end
      default: win = 1'b0;
    endcase

    if (win && (req0_valid || req1_valid) && !rst) begin
      accept     = 1'b1;
      req0_ready = ~grant;
      req1_ready = grant;
    end

    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_OUT;
      ST_OUT:  if (handshake) state_nxt = accept ? ST_CONV : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      res_q      <= '0;
      out_id     <= 1'b0;
      out_valid  <= 1'b0;
      conv_count <= '0;
    end else begin
      if (accept) begin
        samp_q     <= grant ? req1_d : req0_d;
        id_q       <= grant;
        last_grant <= grant;
      end
      if (state == ST_CONV) begin
        res_q  <= cvt_res;
        out_id <= id_q;
      end
      out_valid <= (state_nxt == ST_OUT);
      if (handshake) conv_count <= conv_count + CNT_W'(1);
    end
  end

  assign out_s = res_q.s;
  assign out_e = res_q.e;
  assign out_f = res_q.f;

endmodule

// File: tb/tb_fpcvt_sched.sv
// Directed bench for fpcvt_sched: reset, arbitration, backpressure,
// conversion boundaries, counter wrap and mid-conversion reset.
module tb_fpcvt_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, out_ready;
  logic [12:0] req0_d, req1_d;
  logic        req0_ready, req1_ready, out_valid;
  logic        out_s, out_id;
  logic [2:0]  out_e;
  logic [4:0]  out_f;
  logic [7:0]  conv_count;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_cnt = 8'd0;

  fpcvt_sched #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_d     (req0_d),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_d     (req1_d),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_e      (out_e),
    .out_f      (out_f),
    .out_id     (out_id),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Readys must never both be high
  always @(negedge clk) chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);

  // Single request from an idle scheduler through to its handshake
  task automatic run_one(input logic id, input logic [12:0] d,
                         input logic es, input logic [2:0] ee, input logic [4:0] ef);
    out_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_d = d; end
    else    begin req0_valid = 1'b1; req0_d = d; end
    #1;
    chk("one_ready", 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("one_conv_ov", 32'(out_valid), 32'd0);
    tick();
    chk("one_ov", 32'(out_valid), 32'd1);
    chk("one_res", 32'({out_s, out_e, out_f}), 32'({es, ee, ef}));
    chk("one_id", 32'(out_id), 32'(id));
    tick();
    exp_cnt = exp_cnt + 8'd1;
    chk("one_idle_ov", 32'(out_valid), 32'd0);
    chk("one_cnt", 32'(conv_count), 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_d = '0; req1_d = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(conv_count), 32'd0);
    chk("rst_res", 32'({out_s, out_e, out_f, out_id}), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Tie from reset: requester 0 first, then 1
    req0_valid = 1'b1; req0_d = 13'h1FFF;
    req1_valid = 1'b1; req1_d = 13'd4095;
    #1;
    chk("tie_first", 32'({req1_ready, req0_ready}), 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("tie_conv_ready", 32'({req1_ready, req0_ready}), 32'd0);
    tick();
    chk("tie_ov0", 32'(out_valid), 32'd1);
    chk("tie_res0", 32'({out_s, out_e, out_f, out_id}), 32'({1'b1, 3'd0, 5'd1, 1'b0}));
    chk("tie_ready1", 32'({req1_ready, req0_ready}), 32'd2);
    tick();
    exp_cnt = exp_cnt + 8'd1;
    req1_valid = 1'b0;
    chk("tie_gap_ov", 32'(out_valid), 32'd0);
    chk("tie_cnt0", 32'(conv_count), 32'(exp_cnt));
    tick();
    chk("tie_ov1", 32'(out_valid), 32'd1);
    chk("tie_res1", 32'({out_s, out_e, out_f, out_id}), 32'({1'b0, 3'd7, 5'd31, 1'b1}));
    tick();
    exp_cnt = exp_cnt + 8'd1;
    chk("tie_idle_ov", 32'(out_valid), 32'd0);
    chk("tie_cnt1", 32'(conv_count), 32'(exp_cnt));

    // Back-to-back: ids 0,1,0,1,0 with one result every two cycles
    req0_valid = 1'b1; req0_d = 13'd46;
    req1_valid = 1'b1; req1_d = 13'd5;
    out_ready = 1'b1;
    #1;
    chk("b2b_first", 32'({req1_ready, req0_ready}), 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("b2b_conv_ov", 32'(out_valid), 32'd0);
      chk("b2b_conv_ready", 32'({req1_ready, req0_ready}), 32'd0);
      tick();
      chk("b2b_ov", 32'(out_valid), 32'd1);
      chk("b2b_id", 32'(out_id), 32'(k % 2));
      chk("b2b_res", 32'({out_s, out_e, out_f}),
          (k % 2 == 0) ? 32'({1'b0, 3'd1, 5'd23}) : 32'({1'b0, 3'd0, 5'd5}));
      if (k == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      chk("b2b_next", 32'({req1_ready, req0_ready}),
          (k == 4) ? 32'd0 : ((k % 2 == 0) ? 32'd2 : 32'd1));
      tick();
      exp_cnt = exp_cnt + 8'd1;
      chk("b2b_cnt", 32'(conv_count), 32'(exp_cnt));
    end
    chk("b2b_idle_ov", 32'(out_valid), 32'd0);

    // Backpressure: result held 5 cycles, no grants while stalled
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_d = 13'd46;
    #1;
    chk("bp_accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("bp_ready", 32'({req1_ready, req0_ready}), 32'd0);
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_res", 32'({out_s, out_e, out_f, out_id}), 32'({1'b0, 3'd1, 5'd23, 1'b0}));
      chk("bp_cnt", 32'(conv_count), 32'(exp_cnt));
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 8'd1;
    chk("bp_rel_ov", 32'(out_valid), 32'd0);
    chk("bp_rel_cnt", 32'(conv_count), 32'(exp_cnt));
    tick();
    chk("bp_single", 32'(conv_count), 32'(exp_cnt));

    // Conversion boundaries; 63 rounds up to 64 = 16 * 2^2
    run_one(1'b1, 13'h1000, 1'b1, 3'd7, 5'd31);
    run_one(1'b0, 13'd63,   1'b0, 3'd2, 5'd16);
    run_one(1'b0, 13'd62,   1'b0, 3'd1, 5'd31);
    run_one(1'b1, 13'd0,    1'b0, 3'd0, 5'd0);
    run_one(1'b0, 13'd31,   1'b0, 3'd0, 5'd31);
    run_one(1'b1, 13'd4095, 1'b0, 3'd7, 5'd31);
    run_one(1'b0, 13'h1FD2, 1'b1, 3'd1, 5'd23);
    run_one(1'b1, 13'd1000, 1'b0, 3'd5, 5'd31);

    // Reset while converting discards the sample and restores the tie order
    req0_valid = 1'b1; req0_d = 13'd46;
    #1;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("rc_ov", 32'(out_valid), 32'd0);
    chk("rc_cnt", 32'(conv_count), 32'd0);
    tick();
    chk("rc_discard", 32'(out_valid), 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rc_tie", 32'({req1_ready, req0_ready}), 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Counter wrap after 256 handshakes
    for (int i = 0; i < 256; i++) begin
      run_one(1'(i % 2), 13'd46, 1'b0, 3'd1, 5'd23);
      if (i == 254) chk("wrap_255", 32'(conv_count), 32'd255);
    end
    chk("wrap_zero", 32'(conv_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
